mdu_seq: RTL and testbench
==========================

# mdu_seq

Parametrised sequential multiply/divide unit for the MIPS pipeline's E stage. It owns the HI/LO registers and runs multiply (fixed latency) and radix-2 restoring divide (one quotient bit per cycle). It handles signed and unsigned operands at configurable width and drives `Busy` so that hazard control stalls any MDU-class instruction that issues while an operation is in flight. Exception requests (`Req`) suppress issue of the instruction they flush.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.
- `MUL_CYCLES`, 5, multiply/accumulate latency in cycles; must be ≥ 1.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `SrcA` in WIDTH: operand A (dividend, multiplicand, or mthi/mtlo data).
- `SrcB` in WIDTH: operand B (divisor, multiplier).
- `Start` in 1: issue the operation in `MDUOP` this cycle.
- `MDUOP` in 4: operation code; see `mdu_pkg`.
- `ReadHILO` in 2: 01 selects HI and 10 selects LO; any other value reads 0.
- `Req` in 1: exception/interrupt flush of the E-stage instruction.
- `Busy` out 1: operation in flight.
- `MDUResult` out WIDTH: read data.

## Operation
- Opcodes:
  - 0000 none; 0001 mult; 0010 multu; 0011 div; 0100 divu; 0101 mthi; 0110 mtlo.
  - 0111 madd; 1000 maddu; 1001 msub; 1010 msubu (feature-gated).
  - Any other code is a no-op.
- Issue occurs when `Start`=1, `Req`=0 and state is IDLE. Operands and op are latched at that edge.
- If `Start` and `Req` are both 1, the issue is dropped entirely: no state change, no HI/LO write.
- `Start` while `Busy`=1 is ignored. The pipeline guarantees it does not happen.
- `Req` never cancels an operation already in flight.
- mthi/mtlo:
  - Write HI/LO at the issue edge.
  - No Busy cycle; the new value is readable the next cycle.
- States:
  - IDLE → MUL on mult/multu/madd*/msub*.
  - IDLE → DIV on div/divu.
  - MUL → IDLE when the counter reaches MUL_CYCLES.
  - DIV → IDLE when the counter reaches WIDTH.
- Multiply:
  - Full 2·WIDTH product, signed or unsigned per op.
  - Written to {HI,LO} on the completion edge.
- Divide:
  - Operate on operand magnitudes, then fix signs.
  - Quotient takes the sign of A xor B; remainder takes the sign of A.
  - LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = SrcA.
- Signed overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0.
- `MDUResult` is combinational from HI/LO and `ReadHILO`. It shows the committed HI/LO, even while Busy.

## Timing
- Reset values:
  - HI = LO = 0; state IDLE; counter 0.
  - `Busy` = 0; `MDUResult` = 0.
- Busy is registered and goes high the cycle after the issue edge.
- Multiply: Busy stays high for exactly MUL_CYCLES cycles. HI/LO are updated on the edge that drops Busy.
- Divide: Busy stays high for exactly WIDTH cycles, with the same update rule.
- Back-to-back: a new `Start` is accepted in the first cycle Busy=0.
- Reset mid-operation:
  - Aborts the operation; the result is discarded.
  - HI/LO are cleared.
  - Busy = 0 on the cycle after reset is sampled.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined:
  - Opcodes 0111–1010 are active.
  - The signed/unsigned product is added to or subtracted from the 2·WIDTH value {HI,LO}, modulo 2^(2·WIDTH).
  - Latency is MUL_CYCLES, with the same Busy behaviour as mult.
- Undefined: those opcodes are no-ops. No Busy, no HI/LO change.

## Structure
- `mdu_pkg` holds the following; state width is derived from `$clog2(WIDTH+1)`.
  - MDUOP encodings.
  - ReadHILO encodings.
  - State enum (IDLE, MUL, DIV).
- Sub-module `mdu_div_core`, owning:
  - The iterative restoring divider: remainder/quotient shift registers and the bit counter.
  - Magnitude conversion and sign fix-up.
  - A start/done handshake with `mdu_seq`.
- Multiply is computed at issue into a holding register. The MUL counter only delays the commit.

## Test plan
- Multiply: SrcA=0x7E2, SrcB=0x1C7, mult, one-cycle Start → Busy high for 5 cycles; then LO=0x000E02AE, HI=0.
- Signed divide: div with SrcA=0xFFFFFFF9, SrcB=2 → Busy high for 32 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide by zero: divu with SrcA=0x1234, SrcB=0 → LO=0xFFFFFFFF, HI=0x1234.
- Req and mthi:
  - Start+Req on mult → Busy stays 0 and HI/LO are unchanged.
  - mthi SrcA=0xDEAD with Req=0 → ReadHILO=01 returns 0xDEAD the next cycle.
- Reset mid-divide: assert reset at Busy cycle 10 of a div → Busy=0 and MDUResult=0 the next cycle.
- With `MDU_MADD_EN`: mtlo 0xFFFFFFFF, then maddu 1×1 → after 5 Busy cycles, HI=1, LO=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Opcode and HI/LO read encodings, FSM state type, counter width helper.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;

  localparam logic [1:0] RD_HI = 2'b01;
  localparam logic [1:0] RD_LO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  // Bits needed to count from 0 up to n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, reset, i_start/i_signed/i_a/i_b in; o_done, o_quo, o_rem out.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = cnt_w(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_last;

  assign w_a_neg = i_signed & i_a[WIDTH-1];
  assign w_b_neg = i_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

  // Dividend bits shift out of the quotient register into the remainder.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign o_done = r_run & w_last;

  // Results reflect the step completing this cycle, valid with o_done.
  assign o_quo = r_dz    ? '1
               : r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign o_rem = r_dz    ? r_a
               : r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_a     <= i_a;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= (i_b == '0);
    end else if (r_run) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_run <= 1'b0;
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MDU owning HI/LO: fixed-latency multiply, iterative divide.
// Ports: clk, reset, SrcA, SrcB, Start, MDUOP, ReadHILO, Req; Busy, MDUResult.
// Build option: define MDU_MADD_EN to enable madd/maddu/msub/msubu.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Start,
  input  logic [3:0]       MDUOP,
  input  logic [1:0]       ReadHILO,
  input  logic             Req,
  output logic             Busy,
  output logic [WIDTH-1:0] MDUResult
);

  localparam int MW = cnt_w(MUL_CYCLES);
  localparam int PW = 2 * WIDTH;

  state_e           r_state;
  state_e           w_nx_state;
  logic [MW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [PW-1:0]    r_prod;

  logic             w_issue;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_mthi;
  logic             w_mtlo;
  logic             w_sgn;
  logic             w_acc;
  logic             w_sub;
  logic             w_mul_last;
  logic [PW-1:0]    w_ea;
  logic [PW-1:0]    w_eb;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_hilo;
  logic [PW-1:0]    w_mul_res;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    w_sgn    = 1'b0;
    w_acc    = 1'b0;
    w_sub    = 1'b0;
    case (MDUOP)
      OP_MULT:  begin w_is_mul = 1'b1; w_sgn = 1'b1; end
      OP_MULTU: w_is_mul = 1'b1;
      OP_DIV:   begin w_is_div = 1'b1; w_sgn = 1'b1; end
      OP_DIVU:  w_is_div = 1'b1;
      OP_MTHI:  w_mthi = 1'b1;
      OP_MTLO:  w_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: begin
        w_is_mul = 1'b1; w_sgn = 1'b1; w_acc = 1'b1;
      end
      OP_MADDU: begin
        w_is_mul = 1'b1; w_acc = 1'b1;
      end
      OP_MSUB: begin
        w_is_mul = 1'b1; w_sgn = 1'b1;
        w_acc = 1'b1; w_sub = 1'b1;
      end
      OP_MSUBU: begin
        w_is_mul = 1'b1; w_acc = 1'b1; w_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign w_issue = Start & ~Req & (r_state == S_IDLE);

  // Product computed at issue; the MUL state only delays the commit.
  // HI/LO cannot change while busy, so accumulating against them here is safe.
  assign w_ea   = {{WIDTH{w_sgn & SrcA[WIDTH-1]}}, SrcA};
  assign w_eb   = {{WIDTH{w_sgn & SrcB[WIDTH-1]}}, SrcB};
  assign w_prod = w_ea * w_eb;
  assign w_hilo = {r_hi, r_lo};
  assign w_mul_res = !w_acc ? w_prod
                   : w_sub  ? (w_hilo - w_prod) : (w_hilo + w_prod);

  assign w_mul_last = (r_cnt == MW'(MUL_CYCLES - 1));

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_issue & w_is_div),
    .i_signed (w_sgn),
    .i_a      (SrcA),
    .i_b      (SrcB),
    .o_done   (w_div_done),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  always_comb begin
    w_nx_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue && w_is_mul)      w_nx_state = S_MUL;
        else if (w_issue && w_is_div) w_nx_state = S_DIV;
      end
      S_MUL:   if (w_mul_last) w_nx_state = S_IDLE;
      S_DIV:   if (w_div_done) w_nx_state = S_IDLE;
      default: w_nx_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nx_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_prod <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_issue) begin
            if (w_is_mul) r_prod <= w_mul_res;
            if (w_mthi)   r_hi   <= SrcA;
            if (w_mtlo)   r_lo   <= SrcA;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) {r_hi, r_lo} <= r_prod;
        end
        S_DIV: begin
          if (w_div_done) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (r_state != S_IDLE);

  always_comb begin
    MDUResult = '0;
    if (ReadHILO == RD_HI)      MDUResult = r_hi;
    else if (ReadHILO == RD_LO) MDUResult = r_lo;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: arithmetic reference model plus
// directed vectors with hand-computed HI/LO values and Busy lengths.
module tb_mdu_seq;

  localparam int W  = 32;
  localparam int MC = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         Start = 1'b0;
  logic [3:0]   MDUOP = 4'd0;
  logic [1:0]   ReadHILO = 2'd0;
  logic         Req = 1'b0;
  logic         Busy;
  logic [W-1:0] MDUResult;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu_seq #(
    .WIDTH      (W),
    .MUL_CYCLES (MC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Start     (Start),
    .MDUOP     (MDUOP),
    .ReadHILO  (ReadHILO),
    .Req       (Req),
    .Busy      (Busy),
    .MDUResult (MDUResult)
  );

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: architectural HI/LO, a pending result, and the
  // number of busy cycles still to run.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;
  int           m_left = 0;
  bit           m_ok = 1'b0;

  task automatic model_div(input bit sgn);
    int sa;
    int sb;
    sa = $signed(SrcA);
    sb = $signed(SrcB);
    if (SrcB == '0) begin
      p_lo = '1;
      p_hi = SrcA;
    end else if (sgn && SrcA == 32'h8000_0000 && SrcB == 32'hFFFF_FFFF) begin
      p_lo = 32'h8000_0000;
      p_hi = '0;
    end else if (sgn) begin
      p_lo = sa / sb;
      p_hi = sa % sb;
    end else begin
      p_lo = SrcA / SrcB;
      p_hi = SrcA % SrcB;
    end
    m_left = W;
  endtask

  task automatic model_issue();
    logic [2*W-1:0] sp;
    logic [2*W-1:0] up;
    sp = longint'($signed(SrcA)) * longint'($signed(SrcB));
    up = {32'd0, SrcA} * {32'd0, SrcB};
    case (MDUOP)
      4'd1: begin {p_hi, p_lo} = sp; m_left = MC; end
      4'd2: begin {p_hi, p_lo} = up; m_left = MC; end
      4'd3: model_div(1'b1);
      4'd4: model_div(1'b0);
      4'd5: m_hi = SrcA;
      4'd6: m_lo = SrcA;
`ifdef MDU_MADD_EN
      4'd7:  begin {p_hi, p_lo} = {m_hi, m_lo} + sp; m_left = MC; end
      4'd8:  begin {p_hi, p_lo} = {m_hi, m_lo} + up; m_left = MC; end
      4'd9:  begin {p_hi, p_lo} = {m_hi, m_lo} - sp; m_left = MC; end
      4'd10: begin {p_hi, p_lo} = {m_hi, m_lo} - up; m_left = MC; end
`endif
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_hi   = '0;
      m_lo   = '0;
      m_left = 0;
      m_ok   = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (Start && !Req) begin
      model_issue();
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_busy", W'(Busy), W'(m_left > 0));
      chk("model_result", MDUResult,
          (ReadHILO == 2'b01) ? m_hi :
          (ReadHILO == 2'b10) ? m_lo : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit rq);
    Start = 1'b1;
    MDUOP = op;
    SrcA  = a;
    SrcB  = b;
    Req   = rq;
    tick();
    Start = 1'b0;
    MDUOP = 4'd0;
    Req   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp_n);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk(nm, W'(n), W'(exp_n));
  endtask

  task automatic rd(input logic [1:0] s, output logic [W-1:0] v);
    ReadHILO = s;
    #1;
    v = MDUResult;
  endtask

  task automatic hilo(input string nm, input logic [W-1:0] eh,
                      input logic [W-1:0] el);
    logic [W-1:0] v;
    rd(2'b01, v);
    chk({nm, "_hi"}, v, eh);
    rd(2'b10, v);
    chk({nm, "_lo"}, v, el);
  endtask

  initial begin
    logic [W-1:0] v;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", W'(Busy), '0);
    hilo("reset", '0, '0);
    rd(2'b11, v);
    chk("read_11", v, '0);

    issue(4'd1, 32'h7E2, 32'h1C7, 1'b0);
    wait_idle("mult_busy_len", MC);
    hilo("mult", 32'h0, 32'h000E_02AE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle("div_busy_len", W);
    hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_idle("div2_busy_len", W);
    hilo("div_negb", 32'd1, 32'hFFFF_FFFD);

    issue(4'd4, 32'h1234, 32'd0, 1'b0);
    wait_idle("divu0_busy_len", W);
    hilo("divu_by0", 32'h1234, 32'hFFFF_FFFF);

    issue(4'd1, 32'd3, 32'd4, 1'b1);
    chk("req_busy", W'(Busy), '0);
    tick();
    hilo("req_drop", 32'h1234, 32'hFFFF_FFFF);

    issue(4'd5, 32'hDEAD, 32'd0, 1'b0);
    chk("mthi_busy", W'(Busy), '0);
    hilo("mthi", 32'hDEAD, 32'hFFFF_FFFF);

    issue(4'hF, 32'd9, 32'd9, 1'b0);
    chk("nop_busy", W'(Busy), '0);
    hilo("nop", 32'hDEAD, 32'hFFFF_FFFF);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle("ovf_busy_len", W);
    hilo("div_ovf", 32'h0, 32'h8000_0000);

    issue(4'd3, 32'hFFFF_FF00, 32'd0, 1'b0);
    wait_idle("sdiv0_busy_len", W);
    hilo("div_by0", 32'hFFFF_FF00, 32'hFFFF_FFFF);

    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle("multu_busy_len", MC);
    hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle("mults_busy_len", MC);
    hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    issue(4'd1, 32'd3, 32'd4, 1'b0);
    wait_idle("b2b_mul_len", MC);
    hilo("b2b_mul", 32'd0, 32'd12);
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    wait_idle("b2b_div_len", W);
    hilo("b2b_div", 32'd2, 32'd14);

    issue(4'd3, 32'd1000, 32'd3, 1'b0);
    repeat (9) tick();
    chk("mid_div_busy", W'(Busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_abort_busy", W'(Busy), '0);
    hilo("rst_abort", '0, '0);
    reset = 1'b0;
    tick();

`ifdef MDU_MADD_EN
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    wait_idle("maddu_busy_len", MC);
    hilo("maddu", 32'd1, 32'd0);
    issue(4'd9, 32'd2, 32'd3, 1'b0);
    wait_idle("msub_busy_len", MC);
    hilo("msub", 32'd0, 32'hFFFF_FFFA);
`else
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(4'd8, 32'd1, 32'd1, 1'b0);
    chk("maddu_off_busy", W'(Busy), '0);
    tick();
    hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
